// File: rtl/request_unit.sv
// request_unit: sequential request tracker that sits between the decoder and
// the memory controller. It issues registered data-memory requests, holds them
// until dhit, freezes the PC while a data access is outstanding, and latches
// a sticky halt.
//
// Optional build macro: REQUEST_UNIT_TIMEOUT_EN
//   When defined, a data access that sees no dhit for TIMEOUT consecutive
//   cycles is aborted. The unit then raises mem_err and halt_out and parks
//   in HALTED. When undefined, DATA waits forever and mem_err is tied low.
module request_unit #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cu_dREN,
    input  logic             cu_dWEN,
    input  logic             cu_halt,
    input  logic             ihit,
    input  logic             dhit,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             pcEN,
    output logic             halt_out,
    output logic [CNT_W-1:0] stall_count,
    output logic             mem_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic             dren_reg, dren_next;
    logic             dwen_reg, dwen_next;
    logic             halt_reg, halt_next;
    logic [CNT_W-1:0] stall_reg, stall_next;
    logic             pc_en_comb;
    logic             timeout_hit;

`ifdef REQUEST_UNIT_TIMEOUT_EN
    // The wait counter only has to reach TIMEOUT-1; the abort fires in the
    // cycle that would bring it to TIMEOUT.
    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [TO_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic            mem_err_reg, mem_err_next;

    // Abort condition: still no dhit in the TIMEOUT-th waiting cycle.
    // A dhit in that same cycle wins and completes normally.
    assign timeout_hit = (state_reg == ST_DATA) && !dhit &&
                         (wait_cnt_reg == TO_W'(TIMEOUT - 1));

    // Wait counter: cleared on DATA entry, counts dhit-less DATA cycles.
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if ((state_reg == ST_IDLE) && (state_next == ST_DATA)) begin
            wait_cnt_next = '0;
        end else if ((state_reg == ST_DATA) && !dhit && !timeout_hit) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
        end
        mem_err_next = mem_err_reg | timeout_hit;
    end

    // Timeout counter and sticky error flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wait_cnt_reg <= '0;
            mem_err_reg  <= 1'b0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
            mem_err_reg  <= mem_err_next;
        end
    end

    assign mem_err = mem_err_reg;
`else
    // No timeout hardware: DATA waits indefinitely.
    localparam int unused_timeout = TIMEOUT;

    assign timeout_hit = 1'b0;
    assign mem_err     = 1'b0;
`endif

    // Next-state, request and PC-enable decode.
    always_comb begin
        state_next = state_reg;
        dren_next  = dren_reg;
        dwen_next  = dwen_reg;
        halt_next  = halt_reg;
        stall_next = stall_reg;
        pc_en_comb = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // dhit is meaningless here; only a completed fetch matters.
                if (ihit) begin
                    if (cu_halt) begin
                        // Halt outranks any memory request in the same word.
                        state_next = ST_HALTED;
                        halt_next  = 1'b1;
                    end else if (cu_dWEN) begin
                        // Store wins over load when both are decoded.
                        state_next = ST_DATA;
                        dwen_next  = 1'b1;
                        dren_next  = 1'b0;
                    end else if (cu_dREN) begin
                        state_next = ST_DATA;
                        dren_next  = 1'b1;
                        dwen_next  = 1'b0;
                    end else begin
                        pc_en_comb = 1'b1;
                    end
                end
            end

            ST_DATA: begin
                // Instruction is frozen, so ihit and cu_* are not looked at.
                if (dhit) begin
                    state_next = ST_IDLE;
                    dren_next  = 1'b0;
                    dwen_next  = 1'b0;
                    pc_en_comb = 1'b1;
                end else begin
                    stall_next = (&stall_reg) ? stall_reg : stall_reg + 1'b1;
                    if (timeout_hit) begin
                        state_next = ST_HALTED;
                        dren_next  = 1'b0;
                        dwen_next  = 1'b0;
                        halt_next  = 1'b1;
                    end
                end
            end

            ST_HALTED: begin
                // Terminal: everything held quiet until reset.
                dren_next = 1'b0;
                dwen_next = 1'b0;
                halt_next = 1'b1;
            end

            default: begin
                state_next = ST_IDLE;
                dren_next  = 1'b0;
                dwen_next  = 1'b0;
            end
        endcase
    end

    // State and registered request/halt/stall outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= ST_IDLE;
            dren_reg  <= 1'b0;
            dwen_reg  <= 1'b0;
            halt_reg  <= 1'b0;
            stall_reg <= '0;
        end else begin
            state_reg <= state_next;
            dren_reg  <= dren_next;
            dwen_reg  <= dwen_next;
            halt_reg  <= halt_next;
            stall_reg <= stall_next;
        end
    end

    // Fetch stays enabled except once halted; data priority is resolved
    // downstream in the memory arbiter.
    assign imemREN     = (state_reg != ST_HALTED);
    assign dmemREN     = dren_reg;
    assign dmemWEN     = dwen_reg;
    assign halt_out    = halt_reg;
    assign stall_count = stall_reg;
    // The PC must not move while reset is held, even if ihit is floating high.
    assign pcEN        = pc_en_comb & ~RST;

endmodule

// File: doc/request_unit.md
Name: request_unit

Overview:
- Sequential counterpart to the instruction decoder. It consumes the decoder's per-instruction memory and halt requests (dREN, dWEN, halt) together with the memory hit signals.
- It produces registered data-memory requests to the memory controller, a PC advance enable, and a sticky halt.
- It sits between the decode stage and memory_control in the single-cycle datapath. It holds a data request from issue until dhit and freezes the PC meanwhile.

Parameters:
- CNT_W, 16, width of the data-stall cycle counter.
- TIMEOUT, 255, consecutive no-dhit cycles before abort; used only with REQ_TIMEOUT_EN.

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  asynchronous, active-high reset
- cu_dREN  input  1  decoded load request for the current instruction
- cu_dWEN  input  1  decoded store request for the current instruction
- cu_halt  input  1  decoded HALT for the current instruction
- ihit  input  1  instruction fetch complete this cycle
- dhit  input  1  data access complete this cycle
- imemREN  output  1  instruction read enable
- dmemREN  output  1  registered data read request
- dmemWEN  output  1  registered data write request
- pcEN  output  1  advance PC this cycle (combinational)
- halt_out  output  1  sticky halt, registered
- stall_count  output  CNT_W  cycles spent waiting on dhit, saturating
- mem_err  output  1  sticky timeout error; driven 0 without REQ_TIMEOUT_EN

Behaviour:
- Reset is asynchronous, active-high. It forces:
  - state IDLE
  - dmemREN=0, dmemWEN=0, halt_out=0, stall_count=0, mem_err=0
  - imemREN=1
  - pcEN=0
- States: IDLE, DATA, HALTED.
- IDLE, ihit=0: hold IDLE; pcEN=0.
- IDLE, ihit=1, cu_halt=1: next state HALTED; halt_out=1 from the next edge; pcEN=0. cu_halt has priority over cu_dREN/cu_dWEN.
- IDLE, ihit=1, cu_dWEN=1: next state DATA; dmemWEN=1 and dmemREN=0 from the next edge; pcEN=0.
- IDLE, ihit=1, cu_dREN=1 and cu_dWEN=0: next state DATA; dmemREN=1 from the next edge; pcEN=0.
- Both cu_dREN and cu_dWEN high: dWEN wins; dmemREN stays 0.
- IDLE, ihit=1, no request: stay IDLE; pcEN=1 in the same cycle.
- IDLE: dhit is ignored.
- DATA: dmemREN/dmemWEN held stable until dhit.
  - dhit=1: both cleared at the next edge; next state IDLE; pcEN=1 in the same cycle as dhit.
  - dhit=0: pcEN=0; stall_count increments by 1 per cycle, saturating at 2^CNT_W-1 (no wrap).
- DATA: ihit and cu_* are ignored, since the instruction is frozen while the PC is held.
- HALTED: terminal until RST.
  - imemREN=0, dmemREN=0, dmemWEN=0, pcEN=0, halt_out=1.
  - All inputs ignored.
- imemREN=1 in IDLE and DATA. Memory arbitration gives data priority; this block does not drop imemREN.
- Latency:
  - request visible one cycle after ihit;
  - request release one cycle after dhit;
  - minimum load/store = 2 cycles (issue cycle + dhit cycle).
- stall_count is never cleared except by RST.
- RST asserted mid-DATA drops requests asynchronously. No partial state is retained.

Optional Feature:
- Macro: REQUEST_UNIT_TIMEOUT_EN (referred to above as REQ_TIMEOUT_EN).
- Defined: a timeout counter clears on DATA entry and counts DATA cycles with dhit=0.
  - When it reaches TIMEOUT with dhit still 0, the next edge clears dmemREN/dmemWEN, sets mem_err=1 (sticky), sets halt_out=1, and enters HALTED.
  - dhit arriving in the same cycle the count reaches TIMEOUT takes priority: normal completion, no error.
- Undefined: no timeout counter; DATA waits indefinitely; mem_err tied 0; TIMEOUT unused.

Test Plan:
- RST=1 for 2 cycles, then 0 with ihit=0 -> imemREN=1, dmemREN=0, dmemWEN=0, pcEN=0, halt_out=0, stall_count=0.
- ihit=1, no cu_* request, 5 cycles -> pcEN=1 every cycle; state stays IDLE; stall_count=0.
- Load: ihit=1, cu_dREN=1; dhit held 0 for 3 cycles then 1.
  - dmemREN=1 from cycle+1 until the dhit cycle, 0 after.
  - pcEN=1 only in the dhit cycle; stall_count=3.
- Store with cu_dREN=cu_dWEN=1, ihit=1, dhit the next cycle -> dmemWEN=1 and dmemREN=0 for exactly 1 cycle; pcEN=1 on dhit; stall_count unchanged.
- Halt: ihit=1, cu_halt=1, cu_dWEN=1 -> halt_out=1 next edge, dmemWEN never asserted, imemREN=0; then 10 cycles of ihit/dhit/cu_* toggling -> outputs unchanged; RST -> all reset values.
- With REQUEST_UNIT_TIMEOUT_EN and TIMEOUT=4: load issued, dhit never asserted -> after 4 wait cycles, dmemREN=0, mem_err=1, halt_out=1.
  - Repeat with dhit arriving on wait cycle 4 -> mem_err=0, normal completion.
  - Without the macro -> dmemREN stays 1 indefinitely and mem_err=0.
